// File: rtl/if_fetch_stage.sv
// if_fetch_stage -- instruction-fetch stage of a 5-stage MIPS pipeline.
// Owns the fetch PC, a word-addressed instruction array and a small FIFO
// that hands {instruction, PC+4} pairs to decode over valid/ready.
// Redirects from ID/EX flush the FIFO and reload the PC.
// Optional build macro: IF_PERF_CNT_EN adds saturating fetch/stall/flush
// performance counters as extra outputs.
module if_fetch_stage #(
    parameter int          IM_DEPTH = 128,
    parameter int          FQ_DEPTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fd_ready,
    output logic        fd_valid,
    output logic [31:0] fd_inst,
    output logic [31:0] fd_pc,
    output logic [31:0] pc_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int IDX_W = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FQ_DEPTH);

    // Instruction store, preloaded from outside; there is no write port.
    logic [31:0] instruction [IM_DEPTH];

    // Current fetch address (byte address, always word aligned).
    logic [31:0] PC;

    // Fetch queue storage and bookkeeping.
    logic [31:0]      q_inst [FQ_DEPTH];
    logic [31:0]      q_pc   [FQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [29:0] word_idx;
    logic [31:0] fetch_inst;
    logic [31:0] pc_plus4;
    logic        push;
    logic        pop;

    assign word_idx = PC[31:2];
    assign pc_plus4 = PC + 32'd4;   // wraps 32'hFFFFFFFC -> 0 naturally

    // Handshake: decode consumes the head; fetch enqueues when there is room
    // (or room is being made this edge) and no redirect is pending.
    assign fd_valid = (count != '0);
    assign pop      = fd_valid && fd_ready;
    assign push     = !redirect_valid && ((count < FULL) || pop);

    // Decode sees the queue head directly.
    assign fd_inst = q_inst[rd_ptr];
    assign fd_pc   = q_pc[rd_ptr];
    assign pc_o    = PC;

    // Instruction read: out-of-range word addresses return a nop.
    always_comb begin
        // NOTE: fetch_inst gets a default before the range test so every
        // path assigns it and no latch is inferred.
        fetch_inst = 32'd0;
        if ({2'b00, word_idx} < 32'(IM_DEPTH)) begin
            fetch_inst = instruction[word_idx[IDX_W-1:0]];
        end
    end

    // PC and fetch queue update; redirect flushes and overrides push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values. The queue is only FQ_DEPTH entries and
            // is cleared so fd_inst/fd_pc read 0 out of reset; the
            // instruction array is deliberately not reset so preloaded code
            // survives a reset.
            PC     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_inst[i] <= 32'd0;
                q_pc[i]   <= 32'd0;
            end
        end else if (redirect_valid) begin
            PC     <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_inst[wr_ptr] <= fetch_inst;
                q_pc[wr_ptr]   <= pc_plus4;
                wr_ptr         <= wr_ptr + PTR_W'(1);
                PC             <= pc_plus4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating performance counters: pushes, decode stalls, redirects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (push && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (fd_valid && !fd_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table plus
// hand-written sequences for async reset and the optional perf counters.
module tb_if_fetch_stage;

    localparam int IM_DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_ready;
    logic        fd_valid;
    logic [31:0] fd_inst;
    logic [31:0] fd_pc;
    logic [31:0] pc_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_stage #(
        .IM_DEPTH(IM_DEPTH),
        .FQ_DEPTH(2),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fd_ready      (fd_ready),
        .fd_valid      (fd_valid),
        .fd_inst       (fd_inst),
        .fd_pc         (fd_pc),
        .pc_o          (pc_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Distinct, recognisable code word for each instruction slot.
    function automatic logic [31:0] iw(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ep, input logic [31:0] epc);
        vec_t v;
        v.rst_n = rst_n; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.ep = ep; v.epc = epc;
        vecs.push_back(v);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fd_ready       = 1'b0;
        for (int i = 0; i < IM_DEPTH; i++) begin
            dut.instruction[i] = iw(i);
        end
        #1 rst = 1'b0;
        #1;
        check("reset fd_valid", 32'(fd_valid), 32'd0);
        check("reset pc_o",     pc_o,          32'd0);
        check("reset fd_inst",  fd_inst,       32'd0);
        check("reset fd_pc",    fd_pc,         32'd0);

        // Run a few cycles, then assert reset asynchronously mid-cycle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("prerun pc_o", pc_o, 32'd12);
        #3 rst = 1'b0;
        #1;
        check("midrst fd_valid", 32'(fd_valid), 32'd0);
        check("midrst pc_o",     pc_o,          32'd0);
        check("midrst fd_inst",  fd_inst,       32'd0);
        check("midrst fd_pc",    fd_pc,         32'd0);

        // rst_n rv rpc rdy | valid inst pc+4 PC
        add(1, 0, 32'd0,   1, 1, iw(0),  32'd4,   32'd4);    // release, stream
        add(1, 0, 32'd0,   1, 1, iw(1),  32'd8,   32'd8);
        add(1, 0, 32'd0,   1, 1, iw(2),  32'd12,  32'd12);
        add(0, 0, 32'd0,   0, 0, 32'd0,  32'd0,   32'd0);    // reset held over edge
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd4);    // backpressure
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd8);
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd8);
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd8);
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd8);
        add(1, 0, 32'd0,   0, 1, iw(0),  32'd4,   32'd8);
        add(1, 0, 32'd0,   1, 1, iw(1),  32'd8,   32'd12);   // full with pop
        add(1, 0, 32'd0,   1, 1, iw(2),  32'd12,  32'd16);
        add(1, 0, 32'd0,   0, 1, iw(2),  32'd12,  32'd16);
        add(1, 1, 32'd226, 0, 0, 32'd0,  32'd0,   32'd224);  // redirect while full
        add(1, 0, 32'd0,   0, 1, iw(56), 32'd228, 32'd228);
        add(1, 0, 32'd0,   1, 1, iw(57), 32'd232, 32'd232);
        add(1, 1, 32'd16,  0, 0, 32'd0,  32'd0,   32'd16);   // fill with [4],[5]
        add(1, 0, 32'd0,   0, 1, iw(4),  32'd20,  32'd20);
        add(1, 0, 32'd0,   0, 1, iw(4),  32'd20,  32'd24);
        add(1, 1, 32'd256, 1, 0, 32'd0,  32'd0,   32'd256);  // redirect + pop
        add(1, 0, 32'd0,   0, 1, iw(64), 32'd260, 32'd260);
        add(1, 1, 32'd512, 1, 0, 32'd0,  32'd0,   32'd512);  // past end of memory
        add(1, 0, 32'd0,   1, 1, 32'd0,  32'd516, 32'd516);
        add(1, 1, 32'hFFFF_FFFC, 1, 0, 32'd0, 32'd0, 32'hFFFF_FFFC); // wrap
        add(1, 0, 32'd0,   1, 1, 32'd0,  32'd0,   32'd0);
        add(1, 0, 32'd0,   1, 1, iw(0),  32'd4,   32'd4);
        add(1, 1, 32'h40,  1, 0, 32'd0,  32'd0,   32'h40);   // back-to-back
        add(1, 1, 32'h80,  1, 0, 32'd0,  32'd0,   32'h80);
        add(1, 0, 32'd0,   1, 1, iw(32), 32'h84,  32'h84);

        foreach (vecs[k]) begin
            rst            = vecs[k].rst_n;
            redirect_valid = vecs[k].rv;
            redirect_pc    = vecs[k].rpc;
            fd_ready       = vecs[k].rdy;
            @(posedge clk);
            #1;
            check($sformatf("row%0d fd_valid", k), 32'(fd_valid), 32'(vecs[k].ev));
            check($sformatf("row%0d pc_o", k), pc_o, vecs[k].epc);
            if (vecs[k].ev) begin
                check($sformatf("row%0d fd_inst", k), fd_inst, vecs[k].ei);
                check($sformatf("row%0d fd_pc", k), fd_pc, vecs[k].ep);
            end
        end

`ifdef IF_PERF_CNT_EN
        redirect_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("perf reset fetch", perf_fetch_cnt, 32'd0);
        check("perf reset stall", perf_stall_cnt, 32'd0);
        check("perf reset flush", perf_flush_cnt, 32'd0);
        rst = 1'b1;
        fd_ready = 1'b1;
        repeat (8) @(posedge clk);     // 8 fetches, no stalls
        #1 fd_ready = 1'b0;
        repeat (3) @(posedge clk);     // 3 stall cycles, 1 more fetch
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        fd_ready       = 1'b1;
        @(posedge clk);                // 1 redirect
        #1 redirect_valid = 1'b0;
        @(posedge clk);                // 10th fetch
        #1;
        check("perf fetch", perf_fetch_cnt, 32'd10);
        check("perf stall", perf_stall_cnt, 32'd3);
        check("perf flush", perf_flush_cnt, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
